// File: rtl/alu2.sv
// alu2: handshaked 16-op ALU with a registered result and C/Z/N/V flags.
// Optional serial shifter for ops 12-15, enabled by defining ALU2_SERIAL_SHIFT_EN.
module alu2 #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_c,
    output logic             out_z,
    output logic             out_n,
    output logic             out_v,
    output logic             out_err,
    output logic             busy
);

    localparam logic [3:0] OP_TRANSFER   = 4'd0;
    localparam logic [3:0] OP_INC        = 4'd1;
    localparam logic [3:0] OP_ADD        = 4'd2;
    localparam logic [3:0] OP_ADD_PLUS1  = 4'd3;
    localparam logic [3:0] OP_SUB_MINUS1 = 4'd4;
    localparam logic [3:0] OP_SUB        = 4'd5;
    localparam logic [3:0] OP_DEC        = 4'd6;
    localparam logic [3:0] OP_TRANSFER2  = 4'd7;
    localparam logic [3:0] OP_AND        = 4'd8;
    localparam logic [3:0] OP_OR         = 4'd9;
    localparam logic [3:0] OP_XOR        = 4'd10;
    localparam logic [3:0] OP_NOT        = 4'd11;

    logic [WIDTH-1:0] opnd;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_n;
    logic             c_n;
    logic             v_n;
    logic             err_n;
    logic             accept;

    logic             ld_en;
    logic [WIDTH-1:0] ld_res;
    logic             ld_c;
    logic             ld_v;
    logic             ld_err;

`ifdef ALU2_SERIAL_SHIFT_EN
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;
    localparam logic [SHAMT_W-1:0] ONE = SHAMT_W'(1);

    logic [0:0]         state;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] cnt;
    logic [1:0]         kind;
    logic [SHAMT_W-1:0] amount;
    logic               start_shift;
    logic               final_step;
    logic [WIDTH:0]     step_work;

    // One-bit shift of val; returns {bit shifted out, shifted value}. kind = op[1:0].
    function automatic logic [WIDTH:0] shift_step(input logic [1:0] k, input logic [WIDTH-1:0] val);
        case (k)
            2'd0:    return {val[WIDTH-1], val[WIDTH-2:0], 1'b0};
            2'd1:    return {val[0], 1'b0, val[WIDTH-1:1]};
            2'd2:    return {val[0], val[WIDTH-1], val[WIDTH-1:1]};
            default: return {val[WIDTH-1], val[WIDTH-2:0], val[WIDTH-1]};
        endcase
    endfunction

    assign amount      = in_b[SHAMT_W-1:0];
    assign start_shift = (in_op[3:2] == 2'b11) && (amount > ONE);
    assign final_step  = (state == SHIFT) && (cnt == ONE) && (!out_valid || out_ready);
    assign step_work   = shift_step(kind, work);
    assign busy        = (state == SHIFT);
    assign in_ready    = (state == IDLE) && (!out_valid || out_ready);
`else
    assign busy        = 1'b0;
    assign in_ready    = !out_valid || out_ready;
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        opnd = '0;
        cin  = 1'b0;
        case (in_op)
            OP_INC:        cin = 1'b1;
            OP_ADD:        opnd = in_b;
            OP_ADD_PLUS1: begin opnd = in_b;  cin = 1'b1; end
            OP_SUB_MINUS1: opnd = ~in_b;
            OP_SUB:       begin opnd = ~in_b; cin = 1'b1; end
            OP_DEC:        opnd = '1;
            default:       opnd = '0;
        endcase
        sum = {1'b0, in_a} + {1'b0, opnd} + {{WIDTH{1'b0}}, cin};
    end

    always_comb begin
        res_n = in_a;
        c_n   = 1'b0;
        v_n   = 1'b0;
        err_n = 1'b0;
        case (in_op)
            OP_TRANSFER:  res_n = in_a;
            OP_INC, OP_ADD, OP_ADD_PLUS1, OP_SUB_MINUS1, OP_SUB, OP_DEC: begin
                res_n = sum[WIDTH-1:0];
                c_n   = sum[WIDTH];
                v_n   = (in_a[WIDTH-1] == opnd[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_TRANSFER2: res_n = in_b;
            OP_AND:       res_n = in_a & in_b;
            OP_OR:        res_n = in_a | in_b;
            OP_XOR:       res_n = in_a ^ in_b;
            OP_NOT:       res_n = ~in_a;
            default: begin
`ifdef ALU2_SERIAL_SHIFT_EN
                // For amount > 1 this is the first of the serial steps, parked in work.
                if (amount != '0) {c_n, res_n} = shift_step(in_op[1:0], in_a);
`else
                res_n = in_a;
                err_n = 1'b1;
`endif
            end
        endcase
    end

    always_comb begin
        ld_res = res_n;
        ld_c   = c_n;
        ld_v   = v_n;
        ld_err = err_n;
`ifdef ALU2_SERIAL_SHIFT_EN
        ld_en  = (accept && !start_shift) || final_step;
        if (final_step) begin
            {ld_c, ld_res} = step_work;
            ld_v           = 1'b0;
            ld_err         = 1'b0;
        end
`else
        ld_en  = accept;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_c      <= 1'b0;
            out_z      <= 1'b0;
            out_n      <= 1'b0;
            out_v      <= 1'b0;
            out_err    <= 1'b0;
        end else if (ld_en) begin
            out_valid  <= 1'b1;
            out_result <= ld_res;
            out_c      <= ld_c;
            out_z      <= (ld_res == '0);
            out_n      <= ld_res[WIDTH-1];
            out_v      <= ld_v;
            out_err    <= ld_err;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef ALU2_SERIAL_SHIFT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
            kind  <= 2'd0;
        end else if (state == IDLE) begin
            if (accept && start_shift) begin
                state <= SHIFT;
                work  <= res_n;
                cnt   <= amount - ONE;
                kind  <= in_op[1:0];
            end
        end else if (cnt != ONE) begin
            work <= step_work[WIDTH-1:0];
            cnt  <= cnt - ONE;
        end else if (final_step) begin
            state <= IDLE;
        end
    end
`endif

endmodule

// File: tb/tb_alu2.sv
// Directed-vector bench for alu2 (WIDTH=16); covers both ALU2_SERIAL_SHIFT_EN builds.
module tb_alu2;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_c, out_z, out_n, out_v, out_err;
    logic          busy;
    logic [4:0]    flags;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    always #5 clk = ~clk;

    assign flags = {out_c, out_z, out_n, out_v, out_err};

    alu2 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_c(out_c), .out_z(out_z), .out_n(out_n), .out_v(out_v), .out_err(out_err),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one op for one edge, then drop in_valid; returns #1 after the edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_result", out_result, 0);
        check("rst_flags", flags, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);

        // flags = {C,Z,N,V,ERR}
        issue(4'd2, 16'h7FFF, 16'h0001);
        check("add_valid", out_valid, 1);
        check("add_result", out_result, 16'h8000);
        check("add_flags", flags, 5'b00110);

        issue(4'd5, 16'h0005, 16'h0005);
        check("sub_result", out_result, 16'h0000);
        check("sub_flags", flags, 5'b11000);

        issue(4'd4, 16'h0000, 16'h0000);
        check("subm1_result", out_result, 16'hFFFF);
        check("subm1_flags", flags, 5'b00100);

        issue(4'd6, 16'h8000, 16'h0000);
        check("dec_result", out_result, 16'h7FFF);
        check("dec_flags", flags, 5'b10010);

        issue(4'd3, 16'h00FF, 16'h0100);
        check("addp1_result", out_result, 16'h0200);

        issue(4'd8, 16'hF0F0, 16'h0FF0);
        check("and_result", out_result, 16'h00F0);
        issue(4'd10, 16'hFFFF, 16'hFFFF);
        check("xor_flags", {out_result, flags}, {16'h0000, 5'b01000});
        issue(4'd11, 16'h0000, 16'h1234);
        check("not_result", out_result, 16'hFFFF);
        issue(4'd7, 16'h1111, 16'h2222);
        check("xfer2_result", out_result, 16'h2222);

        // Back-to-back INC stream, one result per cycle.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_op = 4'd1; in_a = 16'(i * 3); in_b = '0;
            @(posedge clk); #1;
            check("inc_stream_valid", out_valid, 1);
            check("inc_stream_result", out_result, 32'(i * 3 + 1));
        end
        in_a = 16'h0000;
        @(posedge clk); #1;
        check("inc_hold_load", out_result, 16'h0001);
        out_ready = 1'b0;
        in_a      = 16'h0005;
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_in_ready", in_ready, 0);
            @(posedge clk); #1;
            check("stall_result", out_result, 16'h0001);
            check("stall_valid", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("drain_valid", out_valid, 0);

`ifdef ALU2_SERIAL_SHIFT_EN
        issue(4'd12, 16'h8001, 16'h0004);
        check("shl_busy", busy, 1);
        check("shl_early_valid", out_valid, 0);
        wait_valid(lat);
        check("shl_latency", lat, 3);
        check("shl_result", out_result, 16'h0010);
        check("shl_flags", flags, 5'b00000);
        check("shl_busy_end", busy, 0);

        issue(4'd14, 16'h8000, 16'h000F);
        wait_valid(lat);
        check("sar_latency", lat, 14);
        check("sar_result", out_result, 16'hFFFF);
        check("sar_flags", flags, 5'b00100);

        issue(4'd15, 16'h8001, 16'h0001);
        check("rol_valid", out_valid, 1);
        check("rol_result", out_result, 16'h0003);
        check("rol_flags", flags, 5'b10000);

        issue(4'd13, 16'h00F1, 16'h0000);
        check("shr0_result", {out_result, flags}, {16'h00F1, 5'b00000});

        issue(4'd13, 16'hF000, 16'h0008);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmid_valid", out_valid, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_in_ready", in_ready, 1);
        repeat (8) @(posedge clk);
        #1 check("rstmid_no_output", out_valid, 0);
`else
        issue(4'd12, 16'h1234, 16'h0003);
        check("shl_off_valid", out_valid, 1);
        check("shl_off_result", out_result, 16'h1234);
        check("shl_off_flags", flags, 5'b00001);
        check("shl_off_busy", busy, 0);
        issue(4'd14, 16'h8000, 16'h0002);
        check("sar_off_flags", {out_result, flags}, {16'h8000, 5'b00101});
        issue(4'd2, 16'h0001, 16'h0001);
        check("err_clear", {out_result, flags}, {16'h0002, 5'b00000});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu2.md
# alu2

Parametrised, handshaked successor to the single-cycle 12-op ALU. Accepts one operation per transfer on a valid/ready input, produces a registered result plus C/Z/N/V flags on a valid/ready output, and adds four shift/rotate ops executed by a serial one-bit-per-cycle shifter. It sits between the operand/dispatch stage and writeback of the datapath.

## Interface

- WIDTH, 16, operand/result width (≥4)
- SHAMT_W, $clog2(WIDTH), shift-amount field width taken from in_b
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept this cycle
- in_op  in  4  opcode
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B / shift amount (low SHAMT_W bits)
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- out_result  out  WIDTH  result
- out_c, out_z, out_n, out_v  out  1 each  carry, zero, negative, signed overflow
- out_err  out  1  opcode not supported in this build
- busy  out  1  serial shift in progress

## Operation

- Opcodes: 0 TRANSFER=a; 1 INC=a+1; 2 ADD=a+b; 3 ADD_PLUS1=a+b+1; 4 SUB_MINUS1=a-b-1; 5 SUB=a-b; 6 DEC=a-1; 7 TRANSFER2=b; 8 AND; 9 OR; 10 XOR; 11 NOT=~a; 12 SHL; 13 SHR (logical); 14 SAR; 15 ROL.
- Arithmetic computed at WIDTH+1 bits; subtraction as a+~b+cin; C = bit WIDTH (C=1 means no borrow); V = signed overflow of the WIDTH-bit two's-complement op.
- Logic/transfer ops: C=0, V=0. Shifts: C = last bit shifted out (0 if amount 0), V=0. All ops: Z = (result==0), N = result[WIDTH-1].
- Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready); one-entry output register, full throughput for ops 0–11.
- FSM: IDLE -> SHIFT on accepted shift op with amount>1; SHIFT -> IDLE when final step written to output. Amount 0 or 1 completes from IDLE like a single-cycle op.
- SHIFT: working register loaded with a, counter with amount; each cycle shifts one bit and decrements; final step requires (!out_valid || out_ready), else SHIFT stalls without shifting.
- Amount ≥ WIDTH impossible (SHAMT_W truncation); ROL by amount mod WIDTH.

## Timing

- Reset: out_valid=0, out_result=0, all flags 0, out_err=0, busy=0, state IDLE; in_ready=1 in first cycle after reset.
- Ops 0–11 and shifts with amount ≤1: accepted at edge T -> out_valid high after edge T, result stable until taken.
- Shift with amount k>1: accepted at T, busy=1 after T, out_valid after edge T+k-1 (k cycles latency incl. acceptance), busy falls same edge.
- Simultaneous out take and new accept: output register reloaded same edge, out_valid stays 1.
- out_valid held with out_ready=0: output and flags frozen, in_ready=0.
- rst during SHIFT: operation discarded, no output produced.

## Configuration

- ALU2_SERIAL_SHIFT_EN defined: serial shifter, SHIFT state and busy logic present; out_err always 0.
- Undefined: no shifter/FSM; ops 12–15 complete in one cycle as TRANSFER (result=a, C=0, V=0, Z/N from a) with out_err=1; busy tied 0.

## Test plan

- WIDTH=16, ADD a=0x7FFF b=0x0001 -> result 0x8000, C=0, V=1, N=1, Z=0, latency 1.
- SUB a=0x0005 b=0x0005 -> result 0x0000, Z=1, C=1; SUB_MINUS1 a=0 b=0 -> 0xFFFF, C=0, N=1.
- Back-to-back INC stream with out_ready=1 -> one result per cycle; drop out_ready for 3 cycles -> in_ready=0, result 0x0001 held unchanged.
- SHL a=0x8001 b=4 (macro on) -> busy 3 cycles, result 0x0010, C=0; SAR a=0x8000 b=15 -> 0xFFFF, C=0; ROL a=0x8001 b=1 -> 0x0003, latency 1.
- rst asserted mid SHR (a=0xF000 b=8) -> out_valid stays 0, busy=0, in_ready=1 next cycle.
- Macro off: SHL a=0x1234 b=3 -> result 0x1234, out_err=1, latency 1.
